// File: rtl/spi_slave_cfg.sv
// SPI slave with selectable CPOL/CPHA and cmd/addr/payload frame split.
// SCLK, CS and MOSI are oversampled in sysclk; TX words pass through a one-deep shadow.
module spi_slave_cfg #(
  parameter int                     FRAME_WIDTH = 24,
  parameter int                     CMD_BITS    = 8,
  parameter int                     ADDR_BITS   = 8,
  parameter logic                   CPOL        = 1'b0,
  parameter logic                   CPHA        = 1'b0,
  parameter int                     SYNC_STAGES = 2,
  parameter logic [FRAME_WIDTH-1:0] TX_IDLE     = '0
) (
  input  logic                                    sysclk,
  input  logic                                    rst_n,
  input  logic                                    sclk,
  input  logic                                    cs,
  input  logic                                    mosi,
  output logic                                    miso,
  output logic                                    miso_oe,
  input  logic [FRAME_WIDTH-1:0]                  tx_data,
  input  logic                                    tx_valid,
  output logic                                    tx_ready,
  output logic [FRAME_WIDTH-1:0]                  o_frame,
  output logic [CMD_BITS-1:0]                     o_cmd,
  output logic [ADDR_BITS-1:0]                    o_addr,
  output logic [FRAME_WIDTH-CMD_BITS-ADDR_BITS-1:0] o_payload,
  output logic                                    rx_dv,
  output logic                                    rx_err,
  output logic                                    busy
);

  localparam int PAYLOAD_BITS = FRAME_WIDTH - CMD_BITS - ADDR_BITS;
  localparam int CNT_W        = $clog2(FRAME_WIDTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_WIDTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic [1:0]             state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [FRAME_WIDTH-1:0] rx_shift, tx_shift, tx_shadow, tx_load;
  logic sclk_now, sclk_old, cs_now, cs_old, mosi_bit;
  logic lead_edge, trail_edge, sample_edge, shift_edge, cs_fall, tx_accept;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= {SYNC_STAGES{CPOL}};
      cs_sync   <= '1;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  assign sclk_now = sclk_sync[SYNC_STAGES-2];
  assign sclk_old = sclk_sync[SYNC_STAGES-1];
  assign cs_now   = cs_sync[SYNC_STAGES-2];
  assign cs_old   = cs_sync[SYNC_STAGES-1];
  assign mosi_bit = mosi_sync[SYNC_STAGES-1];

  assign lead_edge   = (sclk_old == CPOL) && (sclk_now != CPOL);
  assign trail_edge  = (sclk_old != CPOL) && (sclk_now == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign cs_fall     = cs_old && !cs_now;
  assign tx_accept   = tx_valid && tx_ready;
  assign tx_load     = tx_ready ? TX_IDLE : tx_shadow;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      tx_shadow <= '0;
      tx_ready  <= 1'b1;
      miso      <= 1'b0;
      o_frame   <= '0;
      rx_dv     <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      rx_dv  <= 1'b0;
      rx_err <= 1'b0;
      if (state == ST_SHIFT && bit_cnt == FULL_CNT) begin
        o_frame <= rx_shift;
        rx_dv   <= 1'b1;
      end
      if (cs_now) begin
        state <= ST_IDLE;
        miso  <= 1'b0;
        if (state == ST_SHIFT && bit_cnt != '0 && bit_cnt != FULL_CNT)
          rx_err <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cs_fall) begin
              state    <= ST_SHIFT;
              bit_cnt  <= '0;
              rx_shift <= '0;
              tx_shift <= tx_load;
              tx_ready <= 1'b1;
              if (!CPHA) miso <= tx_load[FRAME_WIDTH-1];
            end
          end
          ST_SHIFT: begin
            if (bit_cnt == FULL_CNT) begin
              state <= ST_DONE;
              miso  <= 1'b0;
            end else begin
              if (sample_edge) begin
                rx_shift <= {rx_shift[FRAME_WIDTH-2:0], mosi_bit};
                bit_cnt  <= bit_cnt + 1'b1;
              end
              // CPHA=0 already presented the MSB at CS fall, so each shift edge moves on by one
              if (shift_edge) begin
                miso     <= CPHA ? tx_shift[FRAME_WIDTH-1] : tx_shift[FRAME_WIDTH-2];
                tx_shift <= {tx_shift[FRAME_WIDTH-2:0], 1'b0};
              end
            end
          end
          ST_DONE: miso <= 1'b0;
          default: state <= ST_IDLE;
        endcase
      end
      // Accept after the load so a word offered on the CS-fall cycle waits for the next frame
      if (tx_accept) begin
        tx_shadow <= tx_data;
        tx_ready  <= 1'b0;
      end
    end
  end

  assign miso_oe   = !cs_now;
  assign busy      = (state != ST_IDLE);
  assign o_cmd     = o_frame[FRAME_WIDTH-1 -: CMD_BITS];
  assign o_addr    = o_frame[FRAME_WIDTH-CMD_BITS-1 -: ADDR_BITS];
  assign o_payload = o_frame[PAYLOAD_BITS-1:0];

endmodule

// File: tb/tb_spi_slave_cfg.sv
// Bench for spi_slave_cfg: four instances (SPI modes 0..3) driven in lockstep by one master.
module tb_spi_slave_cfg;
  localparam int FW = 24;
  localparam logic [FW-1:0] TXI = 24'h960FE1;

  logic sysclk = 1'b0;
  logic rst_n = 1'b0;
  logic cs = 1'b1;
  logic tx_valid = 1'b0;
  logic [FW-1:0] tx_data = '0;
  logic sclk_v[4], mosi_v[4], miso_v[4], miso_oe_v[4], tx_ready_v[4];
  logic rx_dv_v[4], rx_err_v[4], busy_v[4];
  logic [FW-1:0] o_frame_v[4];
  logic [7:0] o_cmd_v[4], o_addr_v[4], o_payload_v[4];

  int checks = 0;
  int errors = 0;
  logic [FW-1:0] exp_frames[$];
  int rd_idx[4] = '{0, 0, 0, 0};
  int dv_cnt[4] = '{0, 0, 0, 0};
  int err_cnt[4] = '{0, 0, 0, 0};
  logic [31:0] miso_cap[4];

  always #4 sysclk = ~sysclk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_cfg #(
      .FRAME_WIDTH(FW), .CMD_BITS(8), .ADDR_BITS(8),
      .CPOL(1'(g / 2)), .CPHA(1'(g % 2)), .SYNC_STAGES(2), .TX_IDLE(TXI)
    ) u_dut (
      .sysclk(sysclk), .rst_n(rst_n), .sclk(sclk_v[g]), .cs(cs), .mosi(mosi_v[g]),
      .miso(miso_v[g]), .miso_oe(miso_oe_v[g]), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready_v[g]), .o_frame(o_frame_v[g]), .o_cmd(o_cmd_v[g]),
      .o_addr(o_addr_v[g]), .o_payload(o_payload_v[g]), .rx_dv(rx_dv_v[g]),
      .rx_err(rx_err_v[g]), .busy(busy_v[g])
    );
  end

  function automatic logic cpol(input int m);
    return 1'(m / 2);
  endfunction
  function automatic logic cpha(input int m);
    return 1'(m % 2);
  endfunction

  task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s mode%0d actual=%h expected=%h", nm, m, act, exp);
    end
  endtask

  // Scoreboard consumer: each instance pops its own copy of the expected frame stream
  always @(negedge sysclk) begin
    for (int m = 0; m < 4; m++) begin
      if (rx_err_v[m]) err_cnt[m]++;
      if (rx_dv_v[m]) begin
        dv_cnt[m]++;
        if (rd_idx[m] >= exp_frames.size()) begin
          checks++;
          errors++;
          $display("FAIL rx_dv_unexpected mode%0d actual=%h expected=none", m, o_frame_v[m]);
        end else begin
          chk("o_frame", m, 32'(o_frame_v[m]), 32'(exp_frames[rd_idx[m]]));
          chk("o_cmd", m, 32'(o_cmd_v[m]), 32'(exp_frames[rd_idx[m]][23:16]));
          chk("o_addr", m, 32'(o_addr_v[m]), 32'(exp_frames[rd_idx[m]][15:8]));
          chk("o_payload", m, 32'(o_payload_v[m]), 32'(exp_frames[rd_idx[m]][7:0]));
          rd_idx[m]++;
        end
      end
    end
  end

  task automatic push_tx(input logic [FW-1:0] w);
    @(negedge sysclk);
    tx_data  = w;
    tx_valid = 1'b1;
    @(negedge sysclk);
    tx_valid = 1'b0;
    for (int m = 0; m < 4; m++) chk("tx_ready_after_accept", m, 32'(tx_ready_v[m]), 32'd0);
  endtask

  task automatic run_frame(input logic [31:0] data, input int nbits, input bit raise_cs,
                           input bit tx_fall, input logic [FW-1:0] fall_word);
    logic b;
    for (int m = 0; m < 4; m++) miso_cap[m] = '0;
    @(negedge sysclk);
    cs = 1'b0;
    if (tx_fall) begin
      @(negedge sysclk);
      tx_data  = fall_word;
      tx_valid = 1'b1;
      @(negedge sysclk);
      tx_valid = 1'b0;
      repeat (2) @(negedge sysclk);
    end else begin
      repeat (4) @(negedge sysclk);
    end
    for (int i = 0; i < nbits; i++) begin
      b = data[nbits-1-i];
      for (int m = 0; m < 4; m++) if (!cpha(m)) mosi_v[m] = b;
      repeat (4) @(negedge sysclk);
      for (int m = 0; m < 4; m++) begin
        if (!cpha(m)) miso_cap[m] = {miso_cap[m][30:0], miso_v[m]};
        sclk_v[m] = !cpol(m);
        if (cpha(m)) mosi_v[m] = b;
      end
      repeat (4) @(negedge sysclk);
      for (int m = 0; m < 4; m++) begin
        if (cpha(m)) miso_cap[m] = {miso_cap[m][30:0], miso_v[m]};
        sclk_v[m] = cpol(m);
      end
    end
    repeat (6) @(negedge sysclk);
    if (raise_cs) begin
      cs = 1'b1;
      for (int m = 0; m < 4; m++) mosi_v[m] = 1'b0;
      repeat (8) @(negedge sysclk);
    end
  endtask

  task automatic chk_miso(input string nm, input logic [31:0] exp);
    for (int m = 0; m < 4; m++) chk(nm, m, miso_cap[m], exp);
  endtask

  typedef struct {
    logic [FW-1:0] mosi;
    bit            has_tx;
    logic [FW-1:0] tx;
    logic [FW-1:0] exp_miso;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog mode0 actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    int eb[4];
    logic [FW-1:0] last_frame;
    vecs[0] = '{24'hA1057F, 1'b1, 24'h3C55C3, 24'h3C55C3};
    vecs[1] = '{24'h5A5A5A, 1'b0, 24'h000000, TXI};
    vecs[2] = '{24'hFFFFFF, 1'b1, 24'h800001, 24'h800001};
    vecs[3] = '{24'h000000, 1'b1, 24'hFFFFFF, 24'hFFFFFF};
    vecs[4] = '{24'h800001, 1'b0, 24'h000000, TXI};
    vecs[5] = '{24'h13579B, 1'b1, 24'h2468AC, 24'h2468AC};

    for (int m = 0; m < 4; m++) begin
      sclk_v[m] = cpol(m);
      mosi_v[m] = 1'b0;
    end
    repeat (3) @(negedge sysclk);
    for (int m = 0; m < 4; m++) begin
      chk("rst_miso", m, 32'(miso_v[m]), 32'd0);
      chk("rst_miso_oe", m, 32'(miso_oe_v[m]), 32'd0);
      chk("rst_tx_ready", m, 32'(tx_ready_v[m]), 32'd1);
      chk("rst_o_frame", m, 32'(o_frame_v[m]), 32'd0);
      chk("rst_busy", m, 32'(busy_v[m]), 32'd0);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge sysclk);

    foreach (vecs[v]) begin
      if (vecs[v].has_tx) begin
        for (int m = 0; m < 4; m++) chk("tx_ready_idle", m, 32'(tx_ready_v[m]), 32'd1);
        push_tx(vecs[v].tx);
      end
      exp_frames.push_back(vecs[v].mosi);
      run_frame(32'(vecs[v].mosi), FW, 1'b1, 1'b0, '0);
      chk_miso("vec_miso", 32'(vecs[v].exp_miso));
      for (int m = 0; m < 4; m++) begin
        chk("miso_cs_high", m, 32'(miso_v[m]), 32'd0);
        chk("miso_oe_cs_high", m, 32'(miso_oe_v[m]), 32'd0);
        chk("busy_cs_high", m, 32'(busy_v[m]), 32'd0);
      end
    end
    last_frame = vecs[5].mosi;

    // short frame: 13 bits then CS rise
    for (int m = 0; m < 4; m++) eb[m] = err_cnt[m];
    run_frame(32'(24'hC3A5F0 >> 11), 13, 1'b1, 1'b0, '0);
    for (int m = 0; m < 4; m++) begin
      chk("short_rx_err", m, 32'(err_cnt[m]), 32'(eb[m] + 1));
      chk("short_o_frame_hold", m, 32'(o_frame_v[m]), 32'(last_frame));
    end

    // TX word offered mid-frame goes to the following frame
    exp_frames.push_back(24'h0F1E2D);
    fork
      run_frame(32'(24'h0F1E2D), FW, 1'b1, 1'b0, '0);
      begin
        repeat (60) @(negedge sysclk);
        push_tx(24'h4D2C71);
        for (int m = 0; m < 4; m++) begin
          chk("mid_miso_oe", m, 32'(miso_oe_v[m]), 32'd1);
          chk("mid_busy", m, 32'(busy_v[m]), 32'd1);
        end
      end
    join
    chk_miso("midtx_cur_miso", 32'(TXI));
    for (int m = 0; m < 4; m++) chk("midtx_pending", m, 32'(tx_ready_v[m]), 32'd0);
    exp_frames.push_back(24'h777777);
    run_frame(32'(24'h777777), FW, 1'b1, 1'b0, '0);
    chk_miso("midtx_next_miso", 32'(24'h4D2C71));
    for (int m = 0; m < 4; m++) chk("midtx_ready_after", m, 32'(tx_ready_v[m]), 32'd1);

    // TX word offered exactly on the CS-fall detect cycle
    exp_frames.push_back(24'h314159);
    run_frame(32'(24'h314159), FW, 1'b1, 1'b1, 24'hB00B1E);
    chk_miso("fall_cur_miso", 32'(TXI));
    for (int m = 0; m < 4; m++) chk("fall_pending", m, 32'(tx_ready_v[m]), 32'd0);
    exp_frames.push_back(24'h271828);
    run_frame(32'(24'h271828), FW, 1'b1, 1'b0, '0);
    chk_miso("fall_next_miso", 32'(24'hB00B1E));

    // 30 clocks in a 24-bit frame: extras ignored, MISO low after bit 24
    for (int m = 0; m < 4; m++) eb[m] = err_cnt[m];
    push_tx(24'h1C0DE5);
    exp_frames.push_back(24'hDEADBE);
    run_frame(32'({24'hDEADBE, 6'b101101}), 30, 1'b1, 1'b0, '0);
    chk_miso("long_miso", 32'({24'h1C0DE5, 6'b000000}));
    for (int m = 0; m < 4; m++) chk("long_no_err", m, 32'(err_cnt[m]), 32'(eb[m]));

    // reset pulse after 10 bits with a TX word pending
    for (int m = 0; m < 4; m++) eb[m] = err_cnt[m];
    push_tx(24'h0BADF0);
    run_frame(32'(24'h654321 >> 14), 10, 1'b0, 1'b0, '0);
    rst_n = 1'b0;
    repeat (2) @(negedge sysclk);
    for (int m = 0; m < 4; m++) begin
      chk("mid_rst_miso", m, 32'(miso_v[m]), 32'd0);
      chk("mid_rst_miso_oe", m, 32'(miso_oe_v[m]), 32'd0);
      chk("mid_rst_tx_ready", m, 32'(tx_ready_v[m]), 32'd1);
      chk("mid_rst_o_frame", m, 32'(o_frame_v[m]), 32'd0);
      chk("mid_rst_rx_dv", m, 32'(rx_dv_v[m]), 32'd0);
      chk("mid_rst_rx_err", m, 32'(rx_err_v[m]), 32'd0);
      chk("mid_rst_busy", m, 32'(busy_v[m]), 32'd0);
    end
    cs = 1'b1;
    for (int m = 0; m < 4; m++) mosi_v[m] = 1'b0;
    repeat (2) @(negedge sysclk);
    rst_n = 1'b1;
    repeat (6) @(negedge sysclk);
    for (int m = 0; m < 4; m++) chk("rst_no_err", m, 32'(err_cnt[m]), 32'(eb[m]));
    exp_frames.push_back(24'hA1057F);
    run_frame(32'(24'hA1057F), FW, 1'b1, 1'b0, '0);
    chk_miso("post_rst_miso", 32'(TXI));

    repeat (4) @(negedge sysclk);
    for (int m = 0; m < 4; m++) begin
      chk("frames_consumed", m, 32'(rd_idx[m]), 32'(exp_frames.size()));
      chk("rx_dv_total", m, 32'(dv_cnt[m]), 32'(exp_frames.size()));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
